execute_mdu: RTL and testbench

Parametrised multiply/divide unit for the RV32M/RV64M extension. It sits beside the single-cycle execute stage and receives operands from decode. Multiply ops use a fixed-latency path; divide/remainder ops use an iterative radix-2 restoring divider. Operands enter and results leave through valid/ready handshakes, so the pipeline stalls while the unit is busy.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/execute_mdu_divider.sv | 67 ++++++
 rtl/execute_mdu.sv | 194 +++++++++++++++++++
 tb/tb_execute_mdu.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V types for the execute stage: M-extension op encodings, MDU FSM states
// and small decode helpers for the funct3 field.
package riscv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIN  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

    // DIV and REM are the signed divide forms; DIVU and REMU have funct3[0] set.
    function automatic logic is_signed_div(input logic [2:0] op);
        return op[2] && !op[0];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] op);
        return op[2] && op[1];
    endfunction

endpackage

// File: rtl/execute_mdu_divider.sv
// Unsigned radix-2 restoring divider. The first quotient bit is resolved on the start
// edge from the incoming operands; the remaining XLEN-1 bits take one edge each.
module mdu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            kill_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            last_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int CW = $clog2(XLEN);

    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dsr;

    logic [XLEN-1:0] w_quo_src;
    logic [XLEN-1:0] w_dsr;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_borrow;

    assign w_quo_src = start_i ? dividend_i : r_quo;
    assign w_dsr     = start_i ? divisor_i  : r_dsr;
    assign w_shift   = start_i ? {{XLEN{1'b0}}, dividend_i[XLEN-1]} : {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, w_dsr};
    assign w_borrow  = w_diff[XLEN];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dsr  <= '0;
        end else if (kill_i) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start_i || r_busy) begin
            r_rem <= w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            r_quo <= {w_quo_src[XLEN-2:0], ~w_borrow};
            if (start_i) begin
                r_dsr  <= divisor_i;
                r_cnt  <= CW'(XLEN - 1);
                r_busy <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign last_o      = r_busy && (r_cnt == CW'(1));
    assign quotient_o  = r_quo;
    assign remainder_o = r_rem;

endmodule

// File: rtl/execute_mdu.sv
// RV32M/RV64M multiply/divide unit beside the execute stage. Multiplies take a fixed
// MUL_LATENCY; divides run the iterative divider and a sign-fixup (FIN) cycle.
module execute_mdu
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter int RF_ADDR_W   = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [2:0]           op_i,
    input  logic [XLEN-1:0]      rs1_data_i,
    input  logic [XLEN-1:0]      rs2_data_i,
    input  logic [RF_ADDR_W-1:0] rf_addr_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [XLEN-1:0]      result_o,
    output logic [RF_ADDR_W-1:0] rf_addr_o,
    output logic                 busy_o
);

    localparam bit            MUL_DIRECT = (MUL_LATENCY == 1);
    localparam int            MC_W       = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
    localparam logic [MC_W-1:0] MC_INIT  = MC_W'((MUL_LATENCY >= 2) ? MUL_LATENCY - 2 : 0);

    mdu_state_e           r_state;
    logic [2:0]           r_op;
    logic [RF_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]      r_mul_a;
    logic [XLEN-1:0]      r_mul_b;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [MC_W-1:0]      r_mul_cnt;
    logic [XLEN-1:0]      r_result;
    logic [RF_ADDR_W-1:0] r_rf_addr;
    logic                 r_valid;

    logic            w_accept;
    logic            w_is_div;
    logic            w_signed_div;
    logic            w_is_rem;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_div_start;
    logic            w_div_last;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_fin_res;
    logic [2:0]      w_mul_op;
    logic [XLEN-1:0] w_mul_a;
    logic [XLEN-1:0] w_mul_b;
    logic [XLEN-1:0] w_mul_res;

    function automatic logic [XLEN-1:0] mul_result(input logic [2:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] a_ext;
        logic [2*XLEN-1:0] b_ext;
        logic [2*XLEN-1:0] prod;
        a_ext = (op == OP_MULH || op == OP_MULHSU) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        b_ext = (op == OP_MULH) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        prod  = a_ext * b_ext;
        return (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    // ready_o may follow ready_i combinationally so a retiring result and a new op share an edge.
    assign ready_o  = (r_state == ST_IDLE) || (r_state == ST_DONE && ready_i && !flush_i);
    assign w_accept = valid_i && ready_o && !flush_i;
    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign rf_addr_o = r_rf_addr;
    assign busy_o   = (r_state != ST_IDLE);

    assign w_is_div     = is_div_op(op_i);
    assign w_signed_div = is_signed_div(op_i);
    assign w_is_rem     = is_rem_op(op_i);
    assign w_div_zero   = (rs2_data_i == '0);
    assign w_div_ovf    = w_signed_div && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
    assign w_special_res = w_div_zero ? (w_is_rem ? rs1_data_i : '1)
                                      : (w_is_rem ? '0 : rs1_data_i);

    assign w_abs_a     = (w_signed_div && rs1_data_i[XLEN-1]) ? -rs1_data_i : rs1_data_i;
    assign w_abs_b     = (w_signed_div && rs2_data_i[XLEN-1]) ? -rs2_data_i : rs2_data_i;
    assign w_div_start = w_accept && w_is_div && !w_div_zero && !w_div_ovf;

    mdu_divider #(
        .XLEN (XLEN)
    ) u_divider (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .kill_i      (flush_i),
        .start_i     (w_div_start),
        .dividend_i  (w_abs_a),
        .divisor_i   (w_abs_b),
        .last_o      (w_div_last),
        .quotient_o  (w_quo),
        .remainder_o (w_rem)
    );

    assign w_fin_res = r_op[1] ? (r_neg_r ? -w_rem : w_rem)
                               : (r_neg_q ? -w_quo : w_quo);

    // With a single-cycle multiply the product is formed straight from the operand bus.
    assign w_mul_op  = MUL_DIRECT ? op_i       : r_op;
    assign w_mul_a   = MUL_DIRECT ? rs1_data_i : r_mul_a;
    assign w_mul_b   = MUL_DIRECT ? rs2_data_i : r_mul_b;
    assign w_mul_res = mul_result(w_mul_op, w_mul_a, w_mul_b);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_rd      <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_mul_cnt <= '0;
            r_result  <= '0;
            r_rf_addr <= '0;
            r_valid   <= 1'b0;
        end else if (flush_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_op      <= op_i;
            r_rd      <= rf_addr_i;
            r_mul_a   <= rs1_data_i;
            r_mul_b   <= rs2_data_i;
            r_neg_q   <= w_signed_div && (rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1]);
            r_neg_r   <= w_signed_div && rs1_data_i[XLEN-1];
            r_mul_cnt <= MC_INIT;
            r_valid   <= 1'b0;
            if (!w_is_div) begin
                if (MUL_DIRECT) begin
                    r_state   <= ST_DONE;
                    r_result  <= w_mul_res;
                    r_rf_addr <= rf_addr_i;
                    r_valid   <= 1'b1;
                end else begin
                    r_state <= ST_MUL;
                end
            end else if (w_div_zero || w_div_ovf) begin
                r_state   <= ST_DONE;
                r_result  <= w_special_res;
                r_rf_addr <= rf_addr_i;
                r_valid   <= 1'b1;
            end else begin
                r_state <= ST_DIV;
            end
        end else begin
            case (r_state)
                ST_MUL: begin
                    if (r_mul_cnt == '0) begin
                        r_state   <= ST_DONE;
                        r_result  <= w_mul_res;
                        r_rf_addr <= r_rd;
                        r_valid   <= 1'b1;
                    end else begin
                        r_mul_cnt <= r_mul_cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (w_div_last) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_state   <= ST_DONE;
                    r_result  <= w_fin_res;
                    r_rf_addr <= r_rd;
                    r_valid   <= 1'b1;
                end
                ST_DONE: begin
                    if (ready_i) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_mdu.sv
// Bench for execute_mdu: directed corner cases plus randomized ops against an
// arithmetic reference model, with latency, backpressure, flush and reset checks.
module tb_execute_mdu;

    localparam int XLEN        = 32;
    localparam int MUL_LATENCY = 2;
    localparam int RF_ADDR_W   = 5;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 flush_i = 1'b0;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic [2:0]           op_i = '0;
    logic [XLEN-1:0]      rs1_data_i = '0;
    logic [XLEN-1:0]      rs2_data_i = '0;
    logic [RF_ADDR_W-1:0] rf_addr_i = '0;
    logic                 valid_o;
    logic                 ready_i = 1'b1;
    logic [XLEN-1:0]      result_o;
    logic [RF_ADDR_W-1:0] rf_addr_o;
    logic                 busy_o;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [XLEN-1:0] last_exp = '0;

    execute_mdu #(
        .XLEN        (XLEN),
        .MUL_LATENCY (MUL_LATENCY),
        .RF_ADDR_W   (RF_ADDR_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rf_addr_i  (rf_addr_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .rf_addr_o  (rf_addr_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M semantics from 64-bit integer arithmetic.
    function automatic logic [XLEN-1:0] ref_result(input logic [2:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        longint    sa;
        longint    sb;
        longint    ua;
        longint    ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        if (op < 3'd4) return MUL_LATENCY;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Drives one op and returns just after the accepting edge (E0 + 1ns).
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [RF_ADDR_W-1:0] rd,
                         output bit ok);
        @(negedge clk_i);
        valid_i = 1'b1;
        op_i = op;
        rs1_data_i = a;
        rs2_data_i = b;
        rf_addr_i = rd;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (ok) begin
            @(posedge clk_i);
            #1;
        end else begin
            check("accept_timeout", 64'd0, 64'd1);
        end
        valid_i = 1'b0;
    endtask

    // Latency counts the accepting edge as edge 1.
    task automatic wait_result(input string tag, input int exp_lat,
                               input logic [XLEN-1:0] exp_val, input logic [RF_ADDR_W-1:0] exp_rd);
        int n;
        n = 1;
        while (!valid_o && n < 100) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_res"}, 64'(result_o), 64'(exp_val));
        check({tag, "_rd"}, 64'(rf_addr_o), 64'(exp_rd));
        last_exp = exp_val;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [RF_ADDR_W-1:0] rd);
        bit ok;
        issue(op, a, b, rd, ok);
        if (ok) wait_result(tag, ref_latency(op, a, b), ref_result(op, a, b), rd);
    endtask

    function automatic logic [XLEN-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return XLEN'($urandom_range(0, 20));
            default: return XLEN'($urandom);
        endcase
    endfunction

    initial begin
        bit ok;
        int seen;

        #2 rst_i = 1'b1;
        #1;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_rfaddr", 64'(rf_addr_o), 64'd0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_ready", 64'(ready_o), 64'd1);

        run_op("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
        check("mul_7xm3_exact", 64'(result_o), 64'hFFFF_FFEB);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        check("mulhu_max_exact", 64'(result_o), 64'hFFFF_FFFE);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        run_op("div_m20_3", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd5);
        check("div_m20_3_exact", 64'(result_o), 64'hFFFF_FFFA);
        run_op("rem_m20_3", 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6);
        check("rem_m20_3_exact", 64'(result_o), 64'hFFFF_FFFE);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd7);
        check("divu_100_7_exact", 64'(result_o), 64'd14);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd8);
        check("remu_100_7_exact", 64'(result_o), 64'd2);
        run_op("div_zero", 3'd4, 32'h1234, 32'd0, 5'd9);
        check("div_zero_exact", 64'(result_o), 64'hFFFF_FFFF);
        run_op("rem_zero", 3'd6, 32'h1234, 32'd0, 5'd10);
        check("rem_zero_exact", 64'(result_o), 64'h1234);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        check("div_ovf_exact", 64'(result_o), 64'h8000_0000);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        check("rem_ovf_exact", 64'(result_o), 64'd0);

        // Backpressure: result held while ready_i is low, then retire and accept together.
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, ok);
        if (ok) wait_result("bp_mul", MUL_LATENCY, 32'hFFFF_FFEB, 5'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            valid_i = 1'b1;
            op_i = 3'd5;
            rs1_data_i = 32'd100;
            rs2_data_i = 32'd7;
            rf_addr_i = 5'd3;
            @(posedge clk_i);
            #1;
            check("bp_hold_res", 64'(result_o), 64'hFFFF_FFEB);
            check("bp_hold_rd", 64'(rf_addr_o), 64'd9);
            check("bp_hold_valid", 64'(valid_o), 64'd1);
            check("bp_hold_ready", 64'(ready_o), 64'd0);
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        #1;
        check("bp_ready_follow", 64'(ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        check("bp_retired", 64'(valid_o), 64'd0);
        check("bp_accepted", 64'(busy_o), 64'd1);
        wait_result("bp_divu", XLEN + 1, 32'd14, 5'd3);

        // Flush at divide iteration 10; the op offered in the flush cycle must be dropped.
        issue(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd4, ok);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        valid_i = 1'b1;
        op_i = 3'd0;
        rs1_data_i = 32'd5;
        rs2_data_i = 32'd5;
        rf_addr_i = 5'd15;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush_valid", 64'(valid_o), 64'd0);
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_ready", 64'(ready_o), 64'd1);
        check("flush_keep_res", 64'(result_o), 64'(last_exp));
        seen = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // Asynchronous reset while a multiply is in flight.
        issue(3'd0, 32'd5, 32'd6, 5'd7, ok);
        #2 rst_i = 1'b1;
        #1;
        check("arst_valid", 64'(valid_o), 64'd0);
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_result", 64'(result_o), 64'd0);
        check("arst_rfaddr", 64'(rf_addr_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_op("post_rst_mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd21);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]           op;
            logic [XLEN-1:0]      a;
            logic [XLEN-1:0]      b;
            logic [RF_ADDR_W-1:0] rd;
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = RF_ADDR_W'($urandom_range(0, 31));
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, rd);
        end

        @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
